// File: rtl/cache_trace_driver.sv
// Trace-entry FIFO plus registered access stage that replays {op, addr, last} to the cache.
// Optional CACHE_TRACE_DRIVER_STATS_EN adds saturating read/write/stall counters.
module cache_trace_driver #(
   parameter int ADDRESS_SIZE = 16,
   parameter int TRACE_ADDR_W = 32,
   parameter int DEPTH        = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    trace_valid,
   output logic                    trace_ready,
   input  logic [1:0]              trace_op,
   input  logic [TRACE_ADDR_W-1:0] trace_addr,
   input  logic                    trace_last,
   output logic                    acc_valid,
   input  logic                    acc_ready,
   output logic                    rw,
   output logic [ADDRESS_SIZE-1:0] address,
   output logic                    stat_clr,
   output logic                    addr_err,
   output logic                    done
`ifdef CACHE_TRACE_DRIVER_STATS_EN
  ,output logic [31:0]             n_reads,
   output logic [31:0]             n_writes,
   output logic [31:0]             n_stalls
`endif
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = ADDRESS_SIZE + 3;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "cache_trace_driver: DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   state_e                    state_q, state_d;
   logic [ENTRY_W-1:0]        mem_q [DEPTH];
   logic [ENTRY_W-1:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      rdy_q;
   logic                      acc_valid_q, acc_valid_d;
   logic                      rw_q, rw_d;
   logic [ADDRESS_SIZE-1:0]   address_q, address_d;
   logic                      stat_clr_q, stat_clr_d;
   logic                      addr_err_q, addr_err_d;

   logic                      full, empty, push, pop, load;
   logic [1:0]                head_op;
   logic [ADDRESS_SIZE-1:0]   head_addr;
   logic                      head_last;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   // rdy_q keeps trace_ready low until the first edge after reset release
   assign trace_ready = rdy_q && !full && (state_q != ST_DONE);
   assign push  = trace_valid && trace_ready;
   assign load  = !acc_valid_q || acc_ready;
   assign pop   = load && !empty && (state_q == ST_IDLE || state_q == ST_RUN);
   assign {head_op, head_addr, head_last} = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {trace_op, trace_addr[ADDRESS_SIZE-1:0], trace_last};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      addr_err_d = addr_err_q || (push && |(trace_addr >> ADDRESS_SIZE));
   end

   always_comb begin
      acc_valid_d = acc_valid_q;
      rw_d        = rw_q;
      address_d   = address_q;
      stat_clr_d  = stat_clr_q;
      if (load) begin
         acc_valid_d = 1'b0;
         rw_d        = 1'b0;
         address_d   = '0;
         stat_clr_d  = 1'b0;
         if (pop) begin
            case (head_op)
               2'd0, 2'd1: begin
                  acc_valid_d = 1'b1;
                  rw_d        = head_op[0];
                  address_d   = head_addr;
               end
               2'd2:    stat_clr_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pop) state_d = head_last ? ST_DRAIN : ST_RUN;
         ST_RUN: begin
            if (pop && head_last)  state_d = ST_DRAIN;
            else if (empty && load) state_d = ST_IDLE;
         end
         // final access (or op 2/3 cycle) finishes on the next load edge
         ST_DRAIN: if (load) state_d = ST_DONE;
         default:  state_d = ST_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rdy_q       <= 1'b0;
         acc_valid_q <= 1'b0;
         rw_q        <= 1'b0;
         address_q   <= '0;
         stat_clr_q  <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rdy_q       <= 1'b1;
         acc_valid_q <= acc_valid_d;
         rw_q        <= rw_d;
         address_q   <= address_d;
         stat_clr_q  <= stat_clr_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign acc_valid = acc_valid_q;
   assign rw        = rw_q;
   assign address   = address_q;
   assign stat_clr  = stat_clr_q;
   assign addr_err  = addr_err_q;
   assign done      = (state_q == ST_DONE);

`ifdef CACHE_TRACE_DRIVER_STATS_EN
   logic [31:0] n_reads_q, n_reads_d, n_writes_q, n_writes_d, n_stalls_q, n_stalls_d;

   always_comb begin
      n_reads_d  = n_reads_q;
      n_writes_d = n_writes_q;
      n_stalls_d = n_stalls_q;
      if (acc_valid_q && acc_ready && !rw_q && n_reads_q != '1)  n_reads_d  = n_reads_q + 1;
      if (acc_valid_q && acc_ready && rw_q && n_writes_q != '1)  n_writes_d = n_writes_q + 1;
      if (acc_valid_q && !acc_ready && n_stalls_q != '1)         n_stalls_d = n_stalls_q + 1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_reads_q  <= '0;
         n_writes_q <= '0;
         n_stalls_q <= '0;
      end else begin
         n_reads_q  <= n_reads_d;
         n_writes_q <= n_writes_d;
         n_stalls_q <= n_stalls_d;
      end
   end

   assign n_reads  = n_reads_q;
   assign n_writes = n_writes_q;
   assign n_stalls = n_stalls_q;
`endif

endmodule

// File: tb/tb_cache_trace_driver.sv
// Directed bench for cache_trace_driver: ordering, back-pressure, op 2/3, addr_err, reset.
module tb_cache_trace_driver;

   localparam int AW    = 16;
   localparam int TW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          trace_valid, trace_ready, trace_last;
   logic [1:0]    trace_op;
   logic [TW-1:0] trace_addr;
   logic          acc_valid, acc_ready, rw, stat_clr, addr_err, done;
   logic [AW-1:0] address;
`ifdef CACHE_TRACE_DRIVER_STATS_EN
   logic [31:0]   n_reads, n_writes, n_stalls;
`endif

   int total = 0;
   int fails = 0;

   cache_trace_driver #(.ADDRESS_SIZE(AW), .TRACE_ADDR_W(TW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_op(trace_op),
      .trace_addr(trace_addr), .trace_last(trace_last),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .rw(rw), .address(address),
      .stat_clr(stat_clr), .addr_err(addr_err), .done(done)
`ifdef CACHE_TRACE_DRIVER_STATS_EN
     ,.n_reads(n_reads), .n_writes(n_writes), .n_stalls(n_stalls)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [TW-1:0] a, input logic l);
      trace_valid = 1'b1;
      trace_op    = op;
      trace_addr  = a;
      trace_last  = l;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      trace_valid = 1'b0;
      #2;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      int acc_n, got, sent;
      reset_n = 1'b0; trace_valid = 1'b0; trace_op = 2'd0; trace_addr = '0;
      trace_last = 1'b0; acc_ready = 1'b0;
      tick(); tick();
      check("rst_acc_valid", acc_valid, 0);
      check("rst_trace_ready", trace_ready, 0);
      check("rst_done", done, 0);
      check("rst_addr_err", addr_err, 0);
      check("rst_address", address, 0);
      reset_n = 1'b1;
      tick();
      check("rel_trace_ready", trace_ready, 1);

      // 1: four reads at full rate
      acc_ready = 1'b1;
      drive(2'd0, 32'h10, 1'b0); tick();
      check("t1_first_idle", acc_valid, 0);
      drive(2'd0, 32'h20, 1'b0); tick();
      check("t1_v0", acc_valid, 1); check("t1_a0", address, 16'h10); check("t1_rw0", rw, 0);
      drive(2'd0, 32'h30, 1'b0); tick();
      check("t1_v1", acc_valid, 1); check("t1_a1", address, 16'h20);
      drive(2'd0, 32'h40, 1'b1); tick();
      check("t1_v2", acc_valid, 1); check("t1_a2", address, 16'h30);
      trace_valid = 1'b0; tick();
      check("t1_v3", acc_valid, 1); check("t1_a3", address, 16'h40); check("t1_notdone", done, 0);
      tick();
      check("t1_idle", acc_valid, 0); check("t1_done", done, 1); check("t1_tready", trace_ready, 0);
      tick();
      check("t1_done_sticky", done, 1);

      // 2: write held under back-pressure
      do_reset();
      acc_ready = 1'b0;
      drive(2'd1, 32'h1234, 1'b1); tick();
      trace_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t2_hold_v", acc_valid, 1); check("t2_hold_rw", rw, 1);
         check("t2_hold_a", address, 16'h1234);
      end
      acc_ready = 1'b1; tick();
      check("t2_consumed", acc_valid, 0); check("t2_done", done, 1);
`ifdef CACHE_TRACE_DRIVER_STATS_EN
      check("t2_stalls", n_stalls, 3); check("t2_writes", n_writes, 1); check("t2_reads", n_reads, 0);
`endif

      // 3: fill FIFO plus output register, then drain in order
      do_reset();
      acc_ready = 1'b0; acc_n = 0; sent = 0;
      for (int c = 0; c < 12; c++) begin
         if (!trace_ready) break;
         drive(2'd0, 32'h100 + sent, sent == DEPTH + 1);
         tick();
         acc_n++; sent++;
      end
      check("t3_accepts", acc_n, DEPTH + 1);
      check("t3_full_ready", trace_ready, 0);
      drive(2'd0, 32'h100 + sent, 1'b1);
      acc_ready = 1'b1; got = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         logic took;
         if (acc_valid) begin
            check("t3_order", address, 16'h100 + got);
            got++;
         end
         took = trace_valid && trace_ready;
         tick();
         if (took) begin
            sent++;
            trace_valid = 1'b0;
         end
      end
      check("t3_count", got, DEPTH + 2);
      check("t3_sent", sent, DEPTH + 2);
      check("t3_done", done, 1);

      // 4: read, clear-stats, NOP, write
      do_reset();
      acc_ready = 1'b1;
      drive(2'd0, 32'h50, 1'b0); tick();
      drive(2'd2, 32'h0, 1'b0); tick();
      check("t4_rd_v", acc_valid, 1); check("t4_rd_a", address, 16'h50); check("t4_rd_clr", stat_clr, 0);
      drive(2'd3, 32'h0, 1'b0); tick();
      check("t4_clr_v", acc_valid, 0); check("t4_clr", stat_clr, 1);
      drive(2'd1, 32'h60, 1'b1); tick();
      check("t4_nop_v", acc_valid, 0); check("t4_nop_clr", stat_clr, 0);
      trace_valid = 1'b0; tick();
      check("t4_wr_v", acc_valid, 1); check("t4_wr_rw", rw, 1); check("t4_wr_a", address, 16'h60);
      tick();
      check("t4_done", done, 1);
`ifdef CACHE_TRACE_DRIVER_STATS_EN
      check("t4_reads", n_reads, 1); check("t4_writes", n_writes, 1);
`endif

      // 5: out-of-range address truncated, addr_err sticky
      do_reset();
      acc_ready = 1'b1;
      drive(2'd0, 32'h0001_0004, 1'b1); tick();
      trace_valid = 1'b0;
      check("t5_err_set", addr_err, 1);
      tick();
      check("t5_v", acc_valid, 1); check("t5_a", address, 16'h0004);
      tick(); tick();
      check("t5_err_sticky", addr_err, 1); check("t5_done", done, 1);

      // 6: async reset mid-stream, nothing replayed
      do_reset();
      check("t6_err_cleared", addr_err, 0);
      acc_ready = 1'b0;
      drive(2'd0, 32'h77, 1'b0); tick();
      drive(2'd1, 32'h88, 1'b1); tick();
      trace_valid = 1'b0;
      check("t6_pre_v", acc_valid, 1);
      reset_n = 1'b0; #1;
      check("t6_async_v", acc_valid, 0); check("t6_async_a", address, 0);
      check("t6_async_ready", trace_ready, 0);
      tick();
      reset_n = 1'b1; acc_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t6_no_replay", acc_valid, 0);
      end
      check("t6_not_done", done, 0);
      drive(2'd0, 32'h99, 1'b1); tick();
      trace_valid = 1'b0; tick();
      check("t6_new_v", acc_valid, 1); check("t6_new_a", address, 16'h99);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
